// File: rtl/pov_read_arbiter.sv
// pov_read_arbiter: shares one 16-bit memory read port between CHANNELS APA102
// strip drivers. Grants rotate round-robin and only one read is in flight at a time.
// Optional feature macro: POV_READ_ARBITER_STATS_EN adds stat_clear / stat_reads,
// a saturating count of completed reads.
module pov_read_arbiter #(
   parameter int CHANNELS          = 4,
   parameter int ADDRESS_BUS_WIDTH = 16,
   parameter int MEM_LATENCY       = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [CHANNELS-1:0]                   channel_enable,
   input  logic [CHANNELS-1:0]                   read_request,
   input  logic [CHANNELS*ADDRESS_BUS_WIDTH-1:0] read_address,
   output logic [15:0]                           read_data,
   output logic [CHANNELS-1:0]                   read_finished_strobe,
   output logic [ADDRESS_BUS_WIDTH-1:0]          mem_address,
   output logic                                  mem_read_enable,
   input  logic [15:0]                           mem_read_data,
   output logic                                  busy
`ifdef POV_READ_ARBITER_STATS_EN
   ,
   input  logic                                  stat_clear,
   output logic [31:0]                           stat_reads
`endif
);

   localparam int AW    = ADDRESS_BUS_WIDTH;
   localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int LAT_W = 3;

   // Pointer starts on the last channel so channel 0 wins the first decision.
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CHANNELS - 1);
   localparam logic [PTR_W:0]   CH_COUNT = (PTR_W+1)'(CHANNELS);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    grant_q, grant_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic                en_q, en_d;
   logic                busy_q, busy_d;
   logic [15:0]         data_q, data_d;
   logic [CHANNELS-1:0] strobe_q, strobe_d;

   logic [CHANNELS-1:0] eligible;
   logic [AW-1:0]       slot_address [CHANNELS];
   logic                found;
   logic [PTR_W-1:0]    winner;
   logic [PTR_W:0]      cand;

   // Split the packed address bus into one word per channel.
   always_comb begin
      for (int n = 0; n < CHANNELS; n++) begin
         slot_address[n] = read_address[n*AW +: AW];
      end
   end

   // Round-robin pick: first eligible channel scanning upward from pointer+1.
   always_comb begin
      eligible = read_request & channel_enable;
      found    = 1'b0;
      winner   = ptr_q;
      cand     = '0;
      for (int i = 1; i <= CHANNELS; i++) begin
         cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
         if (cand >= CH_COUNT) begin
            cand = cand - CH_COUNT;
         end
         if (!found && eligible[cand[PTR_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[PTR_W-1:0];
         end
      end
   end

   // Next-state logic: grant in IDLE, count out memory latency, one strobe cycle.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      lat_d    = lat_q;
      addr_d   = addr_q;
      en_d     = 1'b0;
      busy_d   = busy_q;
      data_d   = data_q;
      strobe_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               grant_d = winner;
               ptr_d   = winner;
               addr_d  = slot_address[winner];
               en_d    = 1'b1;
               busy_d  = 1'b1;
               lat_d   = LAT_INIT;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (lat_q == '0) begin
               data_d           = mem_read_data;
               strobe_d[grant_q] = 1'b1;
               state_d          = ST_HOLDOFF;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         ST_HOLDOFF: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; async active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         ptr_q    <= PTR_LAST;
         grant_q  <= '0;
         lat_q    <= '0;
         addr_q   <= '0;
         en_q     <= 1'b0;
         busy_q   <= 1'b0;
         data_q   <= '0;
         strobe_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         lat_q    <= lat_d;
         addr_q   <= addr_d;
         en_q     <= en_d;
         busy_q   <= busy_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
      end
   end

   assign read_data            = data_q;
   assign read_finished_strobe = strobe_q;
   assign mem_address          = addr_q;
   assign mem_read_enable      = en_q;
   assign busy                 = busy_q;

`ifdef POV_READ_ARBITER_STATS_EN
   logic [31:0] stat_q, stat_d;

   // Completed-read counter: clear wins, otherwise count strobe cycles and saturate.
   always_comb begin
      stat_d = stat_q;
      if (stat_clear) begin
         stat_d = '0;
      end else if ((|strobe_q) && (stat_q != 32'hFFFF_FFFF)) begin
         stat_d = stat_q + 32'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign stat_reads = stat_q;
`endif

endmodule

// File: tb/tb_pov_read_arbiter.sv
// tb_pov_read_arbiter: scoreboard bench for pov_read_arbiter with a
// transaction-level round-robin model and a latency-1 memory model.
module tb_pov_read_arbiter;

   localparam int CH  = 4;
   localparam int AW  = 16;
   localparam int LAT = 1;

   logic              clk;
   logic              rst;
   logic [CH-1:0]     channel_enable;
   logic [CH-1:0]     read_request;
   logic [CH*AW-1:0]  read_address;
   logic [15:0]       read_data;
   logic [CH-1:0]     read_finished_strobe;
   logic [AW-1:0]     mem_address;
   logic              mem_read_enable;
   logic [15:0]       mem_read_data = 16'h0000;
   logic              busy;
`ifdef POV_READ_ARBITER_STATS_EN
   logic              stat_clear;
   logic [31:0]       stat_reads;
   logic [31:0]       mdl_stat;
`endif

   pov_read_arbiter #(
      .CHANNELS(CH),
      .ADDRESS_BUS_WIDTH(AW),
      .MEM_LATENCY(LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .channel_enable(channel_enable),
      .read_request(read_request),
      .read_address(read_address),
      .read_data(read_data),
      .read_finished_strobe(read_finished_strobe),
      .mem_address(mem_address),
      .mem_read_enable(mem_read_enable),
      .mem_read_data(mem_read_data),
      .busy(busy)
`ifdef POV_READ_ARBITER_STATS_EN
      ,
      .stat_clear(stat_clear),
      .stat_reads(stat_reads)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: a fixed function of the address (0x0010 -> 0xBEEF).
   function automatic logic [15:0] mem_fn(input logic [15:0] a);
      return a ^ 16'hBEFF;
   endfunction

   // Registered memory: data appears the cycle after the read pulse.
   always @(posedge clk) begin
      if (mem_read_enable) mem_read_data <= mem_fn(mem_address);
   end

   typedef struct {
      int          ch;
      logic [15:0] data;
      int          cyc;
   } txn_t;

   int          total = 0;
   int          bad   = 0;
   int          cyc;
   int          mdl_ptr;
   int          mdl_hold;
   logic        exp_en;
   txn_t        sb_q[$];
   logic [15:0] exp_addr_q[$];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mdl_reset();
      mdl_ptr  = CH - 1;
      mdl_hold = 0;
      cyc      = 0;
      exp_en   = 1'b0;
      sb_q.delete();
      exp_addr_q.delete();
`ifdef POV_READ_ARBITER_STATS_EN
      mdl_stat = 32'd0;
`endif
   endtask

   // One clock edge of the reference: a read occupies the port for LAT+3 cycles,
   // winners rotate starting after the last granted channel.
   task automatic model_step();
      logic [CH-1:0] elig;
      int            w;
      int            c;
      logic [15:0]   a;
      txn_t          t;
      cyc++;
      exp_en = 1'b0;
`ifdef POV_READ_ARBITER_STATS_EN
      if (stat_clear) mdl_stat = 32'd0;
      else if (mdl_hold == 1 && mdl_stat != 32'hFFFF_FFFF) mdl_stat++;
`endif
      if (mdl_hold > 0) begin
         mdl_hold--;
      end else begin
         elig = read_request & channel_enable;
         if (elig != '0) begin
            w = -1;
            for (int k = 1; k <= CH; k++) begin
               c = (mdl_ptr + k) % CH;
               if (w < 0 && elig[c]) w = c;
            end
            a        = read_address[w*AW +: AW];
            mdl_ptr  = w;
            mdl_hold = LAT + 2;
            exp_en   = 1'b1;
            exp_addr_q.push_back(a);
            t.ch   = w;
            t.data = mem_fn(a);
            t.cyc  = cyc + LAT + 1;
            sb_q.push_back(t);
         end
      end
   endtask

   // Reference model runs on every active edge and follows the async reset.
   initial begin
      mdl_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) mdl_reset();
         else model_step();
      end
   end

   // Monitor: compares DUT outputs against the model and pops the scoreboard on strobes.
   initial begin
      txn_t t;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check_output("reset_read_data", read_data, 32'h0);
            check_output("reset_ctrl", {busy, mem_read_enable, read_finished_strobe, mem_address}, 32'h0);
         end else begin
            check_output("busy", busy, mdl_hold > 0);
            check_output("mem_read_enable", mem_read_enable, exp_en);
            if (mem_read_enable) begin
               if (exp_addr_q.size() == 0) check_output("enable_unexpected", mem_read_enable, 32'h0);
               else check_output("mem_address", mem_address, exp_addr_q.pop_front());
            end
            check_output("strobe_present", |read_finished_strobe, mdl_hold == 1);
            if (|read_finished_strobe) begin
               if (sb_q.size() == 0) begin
                  check_output("strobe_unexpected", read_finished_strobe, 32'h0);
               end else begin
                  t = sb_q.pop_front();
                  check_output("strobe_onehot", read_finished_strobe, 32'(1) << t.ch);
                  check_output("read_data", read_data, t.data);
                  check_output("strobe_cycle", cyc, t.cyc);
               end
            end
`ifdef POV_READ_ARBITER_STATS_EN
            check_output("stat_reads", stat_reads, mdl_stat);
`endif
         end
      end
   end

   task automatic apply_stimulus(input logic [CH-1:0] req, input logic [CH-1:0] en,
                                 input logic [CH*AW-1:0] addr, input int cycles);
      @(negedge clk);
      read_request   = req;
      channel_enable = en;
      read_address   = addr;
      repeat (cycles) @(negedge clk);
   endtask

   // Stimulus sequence: reset, directed scenarios, then randomized traffic.
   initial begin
      logic [CH*AW-1:0] slots;
      logic             seen;
      rst            = 1'b0;
      read_request   = '0;
      channel_enable = '0;
      read_address   = '0;
`ifdef POV_READ_ARBITER_STATS_EN
      stat_clear     = 1'b0;
`endif
      slots = {16'h0300, 16'h0200, 16'h0100, 16'h0000};

      repeat (6) begin
         @(negedge clk);
         read_request   = 4'($urandom);
         channel_enable = 4'($urandom);
         read_address   = {$urandom, $urandom};
      end
      @(negedge clk);
      read_request = '0;
      rst          = 1'b1;
      apply_stimulus('0, 4'hF, '0, 20);

      $display("[TB] single requester on channel 1");
      apply_stimulus(4'b0010, 4'hF, {16'h0, 16'h0, 16'h0010, 16'h0}, 12);
      apply_stimulus('0, 4'hF, '0, 6);

      $display("[TB] all channels requesting");
      apply_stimulus(4'hF, 4'hF, slots, 24);
      apply_stimulus('0, 4'hF, slots, 6);

      $display("[TB] enable mask 1010, then drop channel 3 mid-read");
      apply_stimulus(4'hF, 4'b1010, slots, 16);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (mem_read_enable && mem_address == 16'h0300) begin
            read_request[3] = 1'b0;
            seen = 1'b1;
         end
      end
      check_output("ch3_grant_seen", seen, 32'h1);
      repeat (8) @(negedge clk);
      apply_stimulus('0, 4'hF, slots, 6);

      $display("[TB] reset during an in-flight read");
      @(negedge clk);
      read_request   = 4'b0100;
      channel_enable = 4'b0100;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      read_request   = 4'hF;
      channel_enable = 4'hF;
      rst            = 1'b1;
      repeat (10) @(negedge clk);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 9) < 7) read_request = 4'($urandom);
         if (i % 16 == 0) channel_enable = 4'($urandom) | 4'($urandom);
         if ($urandom_range(0, 9) == 0) read_address = {$urandom, $urandom};
      end

`ifdef POV_READ_ARBITER_STATS_EN
      $display("[TB] statistics clear in a strobe cycle");
      read_request   = 4'hF;
      channel_enable = 4'hF;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (|read_finished_strobe) begin
            stat_clear = 1'b1;
            seen = 1'b1;
         end
      end
      check_output("stat_strobe_seen", seen, 32'h1);
      @(negedge clk);
      stat_clear = 1'b0;
      check_output("stat_after_clear", stat_reads, 32'h0);
      repeat (20) @(negedge clk);
`endif

      apply_stimulus('0, 4'hF, slots, 10);
      check_output("scoreboard_empty", sb_q.size(), 32'h0);
      check_output("address_queue_empty", exp_addr_q.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
